// File: rtl/fractal_sync_mp_rf_pkg.sv
// Shared helpers for the multi-port barrier register file.
package fractal_sync_mp_rf_pkg;

  // Age counter width; a disabled timeout still gets a 1-bit (idle) counter.
  function automatic int age_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_mp_rf_entry.sv
// One barrier entry: arrival bitmap, saturating age counter, completion and
// timeout-ready flags.
module fractal_sync_mp_rf_entry
  import fractal_sync_mp_rf_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               flush,
  input  logic [N_PORTS-1:0] set_mask,
  input  logic               tmo_clear,
  output logic [N_PORTS-1:0] bitmap,
  output logic               complete,
  output logic               saturated
);

  localparam int AGE_W = age_width(TIMEOUT);

  logic [N_PORTS-1:0] bitmap_reg, bitmap_next, merged;
  logic [AGE_W-1:0]   age_reg, age_next;

  always_comb begin
    merged      = bitmap_reg | set_mask;
    complete    = (set_mask != '0) && (&merged);
    bitmap_next = merged;
    age_next    = age_reg;
    if (flush || complete || tmo_clear) begin
      bitmap_next = '0;
      age_next    = '0;
    end else if (TIMEOUT == 0 || bitmap_reg == '0) begin
      // An empty entry keeps its age at 0, so the first arrival starts from 0.
      age_next = '0;
    end else if (age_reg != AGE_W'(TIMEOUT)) begin
      age_next = age_reg + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      bitmap_reg <= '0;
      age_reg    <= '0;
    end else begin
      bitmap_reg <= bitmap_next;
      age_reg    <= age_next;
    end
  end

  assign bitmap    = bitmap_reg;
  assign saturated = (TIMEOUT > 0) && (age_reg == AGE_W'(TIMEOUT));

endmodule

// File: rtl/fractal_sync_mp_rf.sv
// Multi-port barrier register file: ports check in on barrier ids, entries
// complete when every port has arrived or are flushed after a timeout.
module fractal_sync_mp_rf
  import fractal_sync_mp_rf_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int N_REGS   = 8,
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [N_PORTS-1:0]                 check_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   id_i,
  output logic [N_PORTS-1:0]                 done_o,
  output logic [N_PORTS-1:0]                 wait_o,
  output logic [N_PORTS-1:0]                 id_err_o,
  output logic [N_PORTS-1:0]                 sig_err_o,
  output logic [N_PORTS-1:0]                 ignore_o,
  output logic                               tmo_valid_o,
  output logic [ID_WIDTH-1:0]                tmo_id_o
);

  logic [N_PORTS-1:0] set_mask [N_REGS];
  logic [N_PORTS-1:0] bitmap   [N_REGS];
  logic [N_REGS-1:0]  complete, saturated, tmo_sel;

  logic [N_PORTS-1:0] in_range, dup, accepted, hit_complete;

  logic [N_PORTS-1:0] done_reg, done_next, wait_reg, wait_next;
  logic [N_PORTS-1:0] id_err_reg, id_err_next, sig_err_reg, sig_err_next;
  logic [N_PORTS-1:0] ignore_reg, ignore_next;
  logic               tmo_valid_reg, tmo_valid_next;
  logic [ID_WIDTH-1:0] tmo_id_reg, tmo_id_next;
  logic               tmo_found;

  // Port-to-entry decode and duplicate detection against the stored bitmap.
  always_comb begin
    in_range = '0;
    dup      = '0;
    accepted = '0;
    for (int r = 0; r < N_REGS; r++) set_mask[r] = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      in_range[p] = int'(id_i[p]) < N_REGS;
      for (int r = 0; r < N_REGS; r++)
        if (int'(id_i[p]) == r) dup[p] = bitmap[r][p];
      accepted[p] = check_i[p] && !flush_i && in_range[p] && !dup[p];
      for (int r = 0; r < N_REGS; r++)
        if (accepted[p] && int'(id_i[p]) == r) set_mask[r][p] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_entry
      fractal_sync_mp_rf_entry #(
        .N_PORTS (N_PORTS),
        .TIMEOUT (TIMEOUT)
      ) u_entry (
        .clk       (clk_i),
        .srst      (rst_i),
        .flush     (flush_i),
        .set_mask  (set_mask[gi]),
        .tmo_clear (tmo_sel[gi]),
        .bitmap    (bitmap[gi]),
        .complete  (complete[gi]),
        .saturated (saturated[gi])
      );
    end
  endgenerate

  // Per-port response: exactly one class for every port that checked.
  always_comb begin
    done_next    = '0;
    wait_next    = '0;
    id_err_next  = '0;
    sig_err_next = '0;
    ignore_next  = '0;
    hit_complete = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      for (int r = 0; r < N_REGS; r++)
        if (int'(id_i[p]) == r) hit_complete[p] = complete[r];
      if (check_i[p]) begin
        if (flush_i)           ignore_next[p]  = 1'b1;
        else if (!in_range[p]) id_err_next[p]  = 1'b1;
        else if (dup[p])       sig_err_next[p] = 1'b1;
        else if (hit_complete[p]) done_next[p] = 1'b1;
        else                   wait_next[p]    = 1'b1;
      end
    end
  end

  // Lowest-index saturated entry that is not completing gets timed out.
  always_comb begin
    tmo_sel     = '0;
    tmo_found   = 1'b0;
    tmo_id_next = '0;
    for (int r = 0; r < N_REGS; r++) begin
      if (!tmo_found && !flush_i && saturated[r] && !complete[r]) begin
        tmo_sel[r]  = 1'b1;
        tmo_id_next = ID_WIDTH'(r);
        tmo_found   = 1'b1;
      end
    end
    tmo_valid_next = tmo_found;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_reg      <= '0;
      wait_reg      <= '0;
      id_err_reg    <= '0;
      sig_err_reg   <= '0;
      ignore_reg    <= '0;
      tmo_valid_reg <= 1'b0;
      tmo_id_reg    <= '0;
    end else begin
      done_reg      <= done_next;
      wait_reg      <= wait_next;
      id_err_reg    <= id_err_next;
      sig_err_reg   <= sig_err_next;
      ignore_reg    <= ignore_next;
      tmo_valid_reg <= tmo_valid_next;
      tmo_id_reg    <= tmo_id_next;
    end
  end

  assign done_o      = done_reg;
  assign wait_o      = wait_reg;
  assign id_err_o    = id_err_reg;
  assign sig_err_o   = sig_err_reg;
  assign ignore_o    = ignore_reg;
  assign tmo_valid_o = tmo_valid_reg;
  assign tmo_id_o    = tmo_id_reg;

endmodule

// File: tb/tb_fractal_sync_mp_rf.sv
// Directed self-checking bench for fractal_sync_mp_rf (4 ports, 8 entries, timeout 16).
module tb_fractal_sync_mp_rf;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [3:0]      check = '0;
  logic [3:0][3:0] id = '0;
  logic [3:0]      done, wt, id_err, sig_err, ignore;
  logic            tmo_valid;
  logic [3:0]      tmo_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fractal_sync_mp_rf #(
    .N_PORTS  (4),
    .N_REGS   (8),
    .ID_WIDTH (4),
    .TIMEOUT  (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .check_i     (check),
    .id_i        (id),
    .done_o      (done),
    .wait_o      (wt),
    .id_err_o    (id_err),
    .sig_err_o   (sig_err),
    .ignore_o    (ignore),
    .tmo_valid_o (tmo_valid),
    .tmo_id_o    (tmo_id)
  );

  wire [19:0] resp = {done, wt, id_err, sig_err, ignore};

  function automatic logic [15:0] ids(input logic [3:0] i3, i2, i1, i0);
    return {i3, i2, i1, i0};
  endfunction

  function automatic logic [19:0] rsp(input logic [3:0] d, w, ie, se, ig);
    return {d, w, ie, se, ig};
  endfunction

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [3:0] chk, input logic [15:0] idv, input logic fl);
    check = chk;
    id    = idv;
    flush = fl;
    @(posedge clk);
    #1;
    check = '0;
    flush = 1'b0;
    $display("t=%0t rst=%b flush=%b chk=%b ids=%h -> done=%b wait=%b id_err=%b sig_err=%b ignore=%b tmo=%b/%0d",
             $time, rst, fl, chk, idv, done, wt, id_err, sig_err, ignore, tmo_valid, tmo_id);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(4'b1111, ids(3, 3, 3, 3), 1'b0);
    checks++;
    if (resp !== 20'h0 || tmo_valid !== 1'b0 || tmo_id !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%h tmo=%b/%0d expected all 0", resp, tmo_valid, tmo_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_two_phase();
    logic [19:0] exp;
    step(4'b0011, ids(0, 0, 3, 3), 1'b0);
    exp = rsp(4'b0000, 4'b0011, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL two_phase_wait: got %h expected %h", resp, exp); end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (resp !== 20'h0) begin errors++; $display("FAIL two_phase_idle: got %h expected %h", resp, 20'h0); end
    step(4'b1100, ids(3, 3, 0, 0), 1'b0);
    exp = rsp(4'b1100, 4'b0000, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL two_phase_done: got %h expected %h", resp, exp); end
    // Entry 3 must be empty again: a fresh arrival only waits.
    step(4'b0001, ids(0, 0, 0, 3), 1'b0);
    exp = rsp(4'b0000, 4'b0001, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL two_phase_empty: got %h expected %h", resp, exp); end
    step(4'b1110, ids(3, 3, 3, 0), 1'b0);
    exp = rsp(4'b1110, 4'b0000, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL two_phase_clean: got %h expected %h", resp, exp); end
  endtask

  task automatic test_all_ports();
    logic [19:0] exp;
    step(4'b1111, ids(5, 5, 5, 5), 1'b0);
    exp = rsp(4'b1111, 4'b0000, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp || tmo_valid !== 1'b0) begin
      errors++; $display("FAIL all_ports_done: got %h tmo=%b expected %h tmo=0", resp, tmo_valid, exp);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (resp !== 20'h0 || tmo_valid !== 1'b0) begin
      errors++; $display("FAIL all_ports_after: got %h tmo=%b expected 0", resp, tmo_valid);
    end
  endtask

  task automatic test_errors();
    logic [19:0] exp;
    step(4'b0010, ids(0, 0, 2, 0), 1'b0);
    exp = rsp(4'b0, 4'b0010, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_first_wait: got %h expected %h", resp, exp); end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    step(4'b0010, ids(0, 0, 2, 0), 1'b0);
    exp = rsp(4'b0, 4'b0, 4'b0, 4'b0010, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_sig: got %h expected %h", resp, exp); end
    step(4'b0001, ids(0, 0, 0, 9), 1'b0);
    exp = rsp(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_id9: got %h expected %h", resp, exp); end
    // Boundary ids: 8 is the first illegal id, 7 the last legal one.
    step(4'b1100, ids(7, 8, 0, 0), 1'b0);
    exp = rsp(4'b0, 4'b1000, 4'b0100, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_boundary: got %h expected %h", resp, exp); end
    step(4'b1101, ids(2, 2, 0, 2), 1'b0);
    exp = rsp(4'b1101, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_clean2: got %h expected %h", resp, exp); end
    step(4'b0111, ids(0, 7, 7, 7), 1'b0);
    exp = rsp(4'b0111, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL err_clean7: got %h expected %h", resp, exp); end
  endtask

  task automatic test_timeout();
    logic [19:0] exp;
    int early;
    step(4'b0001, ids(0, 0, 0, 1), 1'b0);
    step(4'b0001, ids(0, 0, 0, 4), 1'b0);
    exp = rsp(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL tmo_arrivals: got %h expected %h", resp, exp); end
    early = 0;
    for (int i = 0; i < 15; i++) begin
      step(4'b0000, ids(0, 0, 0, 0), 1'b0);
      if (tmo_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL tmo_early: got %0d early pulses expected 0", early); end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b1 || tmo_id !== 4'd1) begin
      errors++; $display("FAIL tmo_first: got %b/%0d expected 1/1", tmo_valid, tmo_id);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b1 || tmo_id !== 4'd4) begin
      errors++; $display("FAIL tmo_second: got %b/%0d expected 1/4", tmo_valid, tmo_id);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b0) begin errors++; $display("FAIL tmo_end: got %b expected 0", tmo_valid); end
    step(4'b0001, ids(0, 0, 0, 1), 1'b0);
    exp = rsp(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL tmo_cleared: got %h expected %h", resp, exp); end
    step(4'b1110, ids(1, 1, 1, 0), 1'b0);
  endtask

  task automatic test_tmo_precedence();
    logic [19:0] exp;
    int early;
    step(4'b0001, ids(0, 0, 0, 6), 1'b0);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'b0000, ids(0, 0, 0, 0), 1'b0);
      if (tmo_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL prec_early: got %0d early pulses expected 0", early); end
    // Entry 6 is saturated now; completing it must win over the timeout.
    step(4'b1110, ids(6, 6, 6, 0), 1'b0);
    exp = rsp(4'b1110, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp || tmo_valid !== 1'b0) begin
      errors++; $display("FAIL prec_done: got %h tmo=%b expected %h tmo=0", resp, tmo_valid, exp);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b0) begin errors++; $display("FAIL prec_after: got %b expected 0", tmo_valid); end
  endtask

  task automatic test_tmo_held();
    logic [19:0] exp;
    int early;
    step(4'b0011, ids(0, 0, 0, 2), 1'b0);
    exp = rsp(4'b0, 4'b0011, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL held_wait: got %h expected %h", resp, exp); end
    early = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'b0000, ids(0, 0, 0, 0), 1'b0);
      if (tmo_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL held_early: got %0d early pulses expected 0", early); end
    step(4'b0100, ids(0, 2, 0, 0), 1'b0);
    exp = rsp(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp || tmo_valid !== 1'b1 || tmo_id !== 4'd0) begin
      errors++; $display("FAIL held_first: got %h tmo=%b/%0d expected %h tmo=1/0", resp, tmo_valid, tmo_id, exp);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b1 || tmo_id !== 4'd2) begin
      errors++; $display("FAIL held_second: got %b/%0d expected 1/2", tmo_valid, tmo_id);
    end
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    checks++;
    if (tmo_valid !== 1'b0) begin errors++; $display("FAIL held_end: got %b expected 0", tmo_valid); end
    step(4'b0100, ids(0, 2, 0, 0), 1'b0);
    exp = rsp(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL held_cleared: got %h expected %h", resp, exp); end
    step(4'b1011, ids(2, 0, 2, 2), 1'b0);
    exp = rsp(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL held_clean: got %h expected %h", resp, exp); end
  endtask

  task automatic test_flush();
    logic [19:0] exp;
    step(4'b0011, ids(0, 0, 6, 6), 1'b0);
    step(4'b0100, ids(0, 6, 0, 0), 1'b1);
    exp = rsp(4'b0, 4'b0, 4'b0, 4'b0, 4'b0100);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL flush_ignore: got %h expected %h", resp, exp); end
    step(4'b0001, ids(0, 0, 0, 6), 1'b0);
    exp = rsp(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL flush_cleared: got %h expected %h", resp, exp); end
    step(4'b1110, ids(6, 6, 6, 0), 1'b0);
    exp = rsp(4'b1110, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL flush_clean: got %h expected %h", resp, exp); end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    step(4'b0111, ids(0, 0, 0, 0), 1'b0);
    rst = 1'b1;
    step(4'b0000, ids(0, 0, 0, 0), 1'b0);
    rst = 1'b0;
    checks++;
    if (resp !== 20'h0 || tmo_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h tmo=%b expected 0", resp, tmo_valid);
    end
    step(4'b1000, ids(0, 0, 0, 0), 1'b0);
    exp = rsp(4'b0, 4'b1000, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL rst_mid_wait: got %h expected %h", resp, exp); end
    step(4'b0111, ids(0, 0, 0, 0), 1'b0);
    exp = rsp(4'b0111, 4'b0, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL rst_mid_clean: got %h expected %h", resp, exp); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    step(4'b1111, ids(9, 2, 1, 1), 1'b0);
    exp = rsp(4'b0, 4'b0111, 4'b1000, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", resp, exp); end
    step(4'b1111, ids(1, 1, 2, 2), 1'b0);
    exp = rsp(4'b1100, 4'b0011, 4'b0, 4'b0, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL b2b_second: got %h expected %h", resp, exp); end
    step(4'b1001, ids(2, 0, 0, 2), 1'b0);
    exp = rsp(4'b1000, 4'b0, 4'b0, 4'b0001, 4'b0);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL b2b_third: got %h expected %h", resp, exp); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_phase();
    test_all_ports();
    test_errors();
    test_timeout();
    test_tmo_precedence();
    test_tmo_held();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_sync_mp_rf.md
FRACTAL_SYNC_MP_RF -- requirements
Module: fractal_sync_mp_rf

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of synchronising ports, legal range >= 2.
REQ-002 SHALL have parameter N_REGS, default 8: number of barrier entries.
REQ-003 SHALL have parameter ID_WIDTH, default 4: barrier id width, with N_REGS <= 2**ID_WIDTH.
REQ-004 SHALL have parameter TIMEOUT, default 16: cycles an incomplete entry may live; 0 disables the timeout.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port flush_i, input, 1 bit: clear all entries.
REQ-008 SHALL have port check_i[N_PORTS], input, 1 bit each: per-port arrival request.
REQ-009 SHALL have port id_i[N_PORTS], input, ID_WIDTH bits each: barrier id of each arrival.
REQ-010 SHALL have port done_o[N_PORTS], output, 1 bit each: the arrival completed its barrier.
REQ-011 SHALL have port wait_o[N_PORTS], output, 1 bit each: the arrival was recorded and the barrier is pending.
REQ-012 SHALL have port id_err_o[N_PORTS], output, 1 bit each: id_i >= N_REGS.
REQ-013 SHALL have port sig_err_o[N_PORTS], output, 1 bit each: duplicate arrival from the same port.
REQ-014 SHALL have port ignore_o[N_PORTS], output, 1 bit each: arrival dropped because of flush_i.
REQ-015 SHALL have port tmo_valid_o, output, 1 bit: one-cycle timeout pulse.
REQ-016 SHALL have port tmo_id_o, output, ID_WIDTH bits: id of the timed-out entry.

Function
REQ-017 SHALL hold, per entry, an N_PORTS-bit arrival bitmap and a saturating age counter of $clog2(TIMEOUT+1) bits.
REQ-018 SHALL register every output, so that the response to a check_i in cycle t appears in cycle t+1 only and is otherwise 0.
REQ-019 SHALL assert exactly one of done_o, wait_o, id_err_o, sig_err_o, ignore_o for each port that checked in cycle t.
REQ-020 SHALL answer id_i >= N_REGS with id_err_o and leave all state unchanged.
REQ-021 SHALL answer an arrival from port p on an entry whose bit p is already set with sig_err_o; that arrival leaves no state change.
REQ-022 SHALL merge all non-error arrivals of a cycle into the entry bitmap; several ports may target the same entry in one cycle.
REQ-023 SHALL clear an entry whose merged bitmap is all ones and its counter, and assert done_o for every port that contributed in that cycle.
REQ-024 SHALL otherwise store the merged bitmap and assert wait_o for the contributing ports.
REQ-025 SHALL reset the age counter of an entry to 0 when its bitmap goes from zero to non-zero.
REQ-026 SHALL increment the age counter each cycle the bitmap is non-zero, saturating at TIMEOUT.
REQ-027 SHALL give completion precedence over timeout when an arrival completes an entry whose counter is at TIMEOUT.
REQ-028 SHALL, with TIMEOUT > 0, flush the lowest-index entry whose counter equals TIMEOUT and is not completing, and pulse tmo_valid_o/tmo_id_o the next cycle.
REQ-029 SHALL hold other entries at TIMEOUT, and report them lowest-index first, one per cycle.
REQ-030 SHALL keep a saturated entry saturated when it receives a non-completing arrival, answer that arrival with wait_o, and still time it out.
REQ-031 SHALL, when TIMEOUT = 0, keep counters inactive and tmo_valid_o at 0 permanently.
REQ-032 SHALL, on flush_i, clear all bitmaps and counters; every check_i in that cycle gets ignore_o, and no timeout is reported for that cycle.

Reset
REQ-033 SHALL, while rst_i is high at a clock edge, clear all bitmaps and counters and drive every output to 0 the next cycle.
REQ-034 SHALL drop a pending arrival or timeout when reset is applied mid-operation, with no later response.
REQ-035 SHALL accept a check_i in the first cycle after rst_i deasserts normally.

Structure
REQ-036 SHALL put no new types in fractal_sync_pkg; widths are localparams derived from the parameters.
REQ-037 SHALL implement one entry as sub-module fractal_sync_mp_rf_entry (bitmap, age counter, completion and timeout flags), instantiated N_REGS times.
REQ-038 SHALL keep port-to-entry decode, duplicate detection and the timeout priority encoder in the top module.

Verification (N_PORTS=4, N_REGS=8, ID_WIDTH=4, TIMEOUT=16)
REQ-039 SHALL cover: ports 0,1 check id 3 in cycle 0, ports 2,3 check id 3 in cycle 2 -> wait_o[0,1]=1 in cycle 1, done_o[2,3]=1 in cycle 3, entry 3 empty.
REQ-040 SHALL cover: all four ports check id 5 in the same cycle -> done_o=1111 next cycle, tmo_valid_o stays 0.
REQ-041 SHALL cover: port 1 checks id 2 twice, 3 cycles apart -> wait_o[1] after the first, sig_err_o[1] after the second; port 0 with id 9 -> id_err_o[0].
REQ-042 SHALL cover: port 0 checks ids 1 and 4 in consecutive cycles with no other arrivals -> tmo_valid_o with tmo_id_o=1, then next cycle tmo_id_o=4.
REQ-043 SHALL cover: flush_i with port 2 checking id 6 while entry 6 holds 0011 -> ignore_o[2]=1, entry 6 cleared, a later port 0 arrival gives wait_o.
REQ-044 SHALL cover: rst_i pulsed one cycle while entry 0 holds 0111 -> all outputs 0, a subsequent port 3 arrival on id 0 gives wait_o, not done_o.
